// File: rtl/rom_seq_alu.sv
// ROM-sequenced register-file ALU: fetch/execute FSM with a program counter that computes
// reg[dst] = reg[src] OP imm, and supports flags, halt and single-step.
module rom_seq_alu #(
  parameter  int unsigned WIDTH   = 8,
  parameter  int unsigned NREGS   = 4,
  parameter  int unsigned PC_W    = 8,
  parameter  int unsigned ROM_LAT = 2,
  localparam int unsigned RSEL_W  = $clog2(NREGS),
  localparam int unsigned IW      = 3 + WIDTH + 2 * RSEL_W
) (
  input  logic              CK,
  input  logic              CLR,
  input  logic              start,
  input  logic              step,
  input  logic [IW-1:0]     rom_data,
  output logic [PC_W-1:0]   rom_addr,
  output logic              rom_oe,
  input  logic [RSEL_W-1:0] dbg_sel,
  output logic [WIDTH-1:0]  dbg_data,
  output logic              busy,
  output logic              halted,
  output logic              carry,
  output logic              zero
);

  localparam int unsigned CNT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALTED} state_e;
  typedef enum logic [2:0] {
    OP_MUL, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LDI, OP_HALT
  } op_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]      ir_q, ir_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic [WIDTH-1:0]   regs_q [NREGS];

  op_e                op;
  logic [WIDTH-1:0]   imm, a, res;
  logic [RSEL_W-1:0]  src, dst;
  logic               res_c, we;
  logic [2*WIDTH-1:0] a_ext, i_ext, prod;
  logic [WIDTH:0]     sum, diff;

  assign op    = op_e'(ir_q[2:0]);
  assign imm   = ir_q[WIDTH+2:3];
  assign src   = ir_q[WIDTH+3 +: RSEL_W];
  assign dst   = ir_q[WIDTH+3+RSEL_W +: RSEL_W];
  assign a     = regs_q[src];
  assign a_ext = {{WIDTH{1'b0}}, a};
  assign i_ext = {{WIDTH{1'b0}}, imm};
  assign prod  = a_ext * i_ext;
  assign sum   = {1'b0, a} + {1'b0, imm};
  // The wrapped top bit of the extended difference is the borrow.
  assign diff  = {1'b0, a} - {1'b0, imm};

  always_comb begin
    res   = '0;
    res_c = carry_q;
    unique case (op)
      OP_MUL:  begin res = prod[WIDTH-1:0]; res_c = |prod[2*WIDTH-1:WIDTH]; end
      OP_ADD:  begin res = sum[WIDTH-1:0];  res_c = sum[WIDTH];             end
      OP_SUB:  begin res = diff[WIDTH-1:0]; res_c = diff[WIDTH];            end
      OP_AND:  begin res = a & imm;         res_c = 1'b0;                   end
      OP_OR:   begin res = a | imm;         res_c = 1'b0;                   end
      OP_XOR:  begin res = a ^ imm;         res_c = 1'b0;                   end
      OP_LDI:  res = imm;
      default: res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    ir_d    = ir_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    we      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          cnt_d   = CNT_W'(ROM_LAT - 1);
        end
      end
      S_FETCH: begin
        if (cnt_q == '0) begin
          ir_d    = rom_data;
          state_d = S_EXEC;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_EXEC: begin
        if (op == OP_HALT) begin
          state_d = S_HALTED;
        end else begin
          we      = 1'b1;
          carry_d = res_c;
          zero_d  = (res == '0);
          pc_d    = pc_q + 1'b1;
          state_d = step ? S_IDLE : S_FETCH;
          cnt_d   = CNT_W'(ROM_LAT - 1);
        end
      end
      S_HALTED: begin
        if (start) begin
          pc_d    = '0;
          state_d = S_FETCH;
          cnt_d   = CNT_W'(ROM_LAT - 1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CK or posedge CLR) begin
    if (CLR) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      ir_q    <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      ir_q    <= ir_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  always_ff @(posedge CK or posedge CLR) begin
    if (CLR) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we) begin
      regs_q[dst] <= res;
    end
  end

  assign rom_addr = pc_q;
  assign rom_oe   = (state_q == S_FETCH);
  assign busy     = (state_q == S_FETCH) || (state_q == S_EXEC);
  assign halted   = (state_q == S_HALTED);
  assign carry    = carry_q;
  assign zero     = zero_q;
  assign dbg_data = regs_q[dbg_sel];

endmodule

// File: tb/tb_rom_seq_alu.sv
// Scoreboard bench for rom_seq_alu: stimulus pushes expected post-instruction state,
// a monitor pops and compares after every executed instruction.
module tb_rom_seq_alu;

  logic        CK, CLR, start, step, start_w;
  logic [14:0] rom_data, romw_data;
  logic [7:0]  rom_addr;
  logic [1:0]  rom_addr_w;
  logic        rom_oe, rom_oe_w;
  logic [1:0]  dbg_sel, dbg_sel_w;
  logic [7:0]  dbg_data, dbg_data_w;
  logic        busy, halted, carry, zero;
  logic        busy_w, halted_w, carry_w, zero_w;

  logic [14:0] rom [256];

  typedef struct {
    logic [1:0] r;
    logic [7:0] v;
    logic       c;
    logic       z;
    logic [7:0] pc;
    logic       h;
  } exp_t;
  exp_t sb[$];

  int unsigned errs = 0;
  int unsigned checks = 0;

  rom_seq_alu u_dut (
    .CK(CK), .CLR(CLR), .start(start), .step(step), .rom_data(rom_data),
    .rom_addr(rom_addr), .rom_oe(rom_oe), .dbg_sel(dbg_sel), .dbg_data(dbg_data),
    .busy(busy), .halted(halted), .carry(carry), .zero(zero)
  );

  rom_seq_alu #(.PC_W(2)) u_wrap (
    .CK(CK), .CLR(CLR), .start(start_w), .step(1'b0), .rom_data(romw_data),
    .rom_addr(rom_addr_w), .rom_oe(rom_oe_w), .dbg_sel(dbg_sel_w), .dbg_data(dbg_data_w),
    .busy(busy_w), .halted(halted_w), .carry(carry_w), .zero(zero_w)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  // Two-cycle ROM: one register stage, sampled by the DUT on its second FETCH cycle.
  always @(posedge CK) rom_data <= rom[rom_addr];

  function automatic logic [14:0] enc(input logic [2:0] op, input logic [7:0] imm,
                                      input logic [1:0] src, input logic [1:0] dst);
    return {dst, src, imm, op};
  endfunction

  assign romw_data = enc(3'b001, 8'h01, 2'd0, 2'd0);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] r, input logic [7:0] v, input logic c,
                      input logic z, input logic [7:0] pc, input logic h);
    exp_t e;
    e.r = r; e.v = v; e.c = c; e.z = z; e.pc = pc; e.h = h;
    sb.push_back(e);
  endtask

  // Monitor: one negedge after an EXEC cycle the architectural state is updated.
  initial begin
    logic pending;
    exp_t e;
    pending = 1'b0;
    forever begin
      @(negedge CK);
      if (pending) begin
        if (sb.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_exec: got=pc%0h expected=none", rom_addr);
        end else begin
          e = sb.pop_front();
          dbg_sel = e.r;
          #1;
          chk("exec_reg", dbg_data, e.v);
          chk("exec_carry", carry, e.c);
          chk("exec_zero", zero, e.z);
          chk("exec_pc", rom_addr, e.pc);
          chk("exec_halted", halted, e.h);
        end
      end
      pending = busy && !rom_oe && !CLR;
    end
  end

  task automatic reset_checks(input string nm);
    @(negedge CK);
    chk({nm, "_addr"}, rom_addr, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_halted"}, halted, 0);
    chk({nm, "_carry"}, carry, 0);
    chk({nm, "_zero"}, zero, 0);
    chk({nm, "_rom_oe"}, rom_oe, 0);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      chk({nm, "_reg"}, dbg_data, 0);
    end
  endtask

  task automatic do_reset();
    @(negedge CK);
    CLR = 1'b1;
    @(negedge CK);
    CLR = 1'b0;
  endtask

  task automatic run_prog(input string nm);
    int unsigned n;
    @(negedge CK);
    start = 1'b1;
    @(negedge CK);
    start = 1'b0;
    n = 0;
    while (!halted && n < 100) begin
      @(negedge CK);
      n++;
    end
    chk({nm, "_halt_cycles"}, n, 12);
    chk({nm, "_halt_addr"}, rom_addr, 3);
    @(negedge CK);
  endtask

  task automatic load_a();
    rom[0] = enc(3'b110, 8'h05, 2'd0, 2'd1);
    rom[1] = enc(3'b001, 8'h03, 2'd1, 2'd2);
    rom[2] = enc(3'b000, 8'h20, 2'd2, 2'd3);
    rom[3] = enc(3'b111, 8'h00, 2'd0, 2'd0);
  endtask

  task automatic push_a();
    push(2'd1, 8'h05, 1'b0, 1'b0, 8'd1, 1'b0);
    push(2'd2, 8'h08, 1'b0, 1'b0, 8'd2, 1'b0);
    push(2'd3, 8'h00, 1'b1, 1'b1, 8'd3, 1'b0);
    push(2'd2, 8'h08, 1'b1, 1'b1, 8'd3, 1'b1);
  endtask

  initial begin
    int unsigned n;
    CLR = 1'b1; start = 1'b0; step = 1'b0; start_w = 1'b0;
    dbg_sel = '0; dbg_sel_w = '0;
    for (int i = 0; i < 256; i++) rom[i] = '0;
    repeat (3) @(negedge CK);
    CLR = 1'b0;
    reset_checks("por");

    load_a();
    push_a();
    run_prog("progA");

    // Registers and flags carry over from program A across the HALTED restart.
    rom[0] = enc(3'b110, 8'hFF, 2'd0, 2'd0);
    rom[1] = enc(3'b001, 8'h01, 2'd0, 2'd0);
    rom[2] = enc(3'b010, 8'h01, 2'd0, 2'd1);
    rom[3] = enc(3'b111, 8'h00, 2'd0, 2'd0);
    push(2'd0, 8'hFF, 1'b1, 1'b0, 8'd1, 1'b0);
    push(2'd0, 8'h00, 1'b1, 1'b1, 8'd2, 1'b0);
    push(2'd1, 8'hFF, 1'b1, 1'b0, 8'd3, 1'b0);
    push(2'd0, 8'h00, 1'b1, 1'b0, 8'd3, 1'b1);
    run_prog("progB");

    do_reset();
    reset_checks("midrun_reset");

    rom[0] = enc(3'b001, 8'h01, 2'd0, 2'd0);
    rom[1] = enc(3'b001, 8'h02, 2'd0, 2'd1);
    rom[2] = enc(3'b001, 8'hFF, 2'd1, 2'd2);
    push(2'd0, 8'h01, 1'b0, 1'b0, 8'd1, 1'b0);
    push(2'd1, 8'h03, 1'b0, 1'b0, 8'd2, 1'b0);
    push(2'd2, 8'h02, 1'b1, 1'b0, 8'd3, 1'b0);
    step = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CK);
      start = 1'b1;
      @(negedge CK);
      start = 1'b0;
      n = 0;
      while (busy && n < 20) begin
        n++;
        @(negedge CK);
      end
      chk("step_busy_cycles", n, 3);
      repeat (2) @(negedge CK);
      chk("step_addr", rom_addr, 32'(k + 1));
      chk("step_idle", busy, 0);
    end
    step = 1'b0;

    do_reset();
    load_a();
    push(2'd1, 8'h05, 1'b0, 1'b0, 8'd1, 1'b0);
    @(negedge CK);
    start = 1'b1;
    @(negedge CK);
    start = 1'b0;
    repeat (4) @(negedge CK);
    chk("clr_pre_addr", rom_addr, 1);
    chk("clr_pre_oe", rom_oe, 1);
    CLR = 1'b1;
    #1;
    chk("clr_addr", rom_addr, 0);
    chk("clr_busy", busy, 0);
    dbg_sel = 2'd1;
    #1;
    chk("clr_r1", dbg_data, 0);
    @(negedge CK);
    CLR = 1'b0;
    push_a();
    run_prog("rerun");

    @(negedge CK);
    start_w = 1'b1;
    @(negedge CK);
    start_w = 1'b0;
    repeat (12) @(negedge CK);
    dbg_sel_w = 2'd0;
    #1;
    chk("wrap4_addr", rom_addr_w, 0);
    chk("wrap4_r0", dbg_data_w, 4);
    repeat (6) @(negedge CK);
    #1;
    chk("wrap6_r0", dbg_data_w, 6);
    chk("wrap6_halted", halted_w, 0);
    chk("wrap6_addr", rom_addr_w, 2);

    repeat (3) @(negedge CK);
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rom_seq_alu.md
Name: rom_seq_alu

Overview:
- ROM-sequenced register-file datapath with a built-in program counter and fetch/execute FSM.
- Each instruction word supplies an opcode, an immediate, a source register select and a destination register select; the block computes reg[src] OP imm and writes the result to reg[dst].
- Sits between an external instruction ROM (addressed by rom_addr) and board-level LEDs/debug.
- Generalises width, register count and op set; adds flags, halt and single-step.

Parameters:
- WIDTH, 8, datapath and immediate width in bits
- NREGS, 4, number of registers; power of 2, >=2; RSEL_W = log2(NREGS)
- PC_W, 8, program counter / ROM address width
- ROM_LAT, 2, ROM read latency in cycles, >=1
- Derived: IW = 3 + WIDTH + 2*RSEL_W (default 15)

Ports:
- CK  in  1  clock, rising edge
- CLR  in  1  asynchronous reset, active-high
- start  in  1  start/continue request, sampled in IDLE/HALTED
- step  in  1  1 = execute one instruction per start
- rom_data  in  IW  instruction word from ROM
- rom_addr  out  PC_W  current PC
- rom_oe  out  1  ROM output enable, high in FETCH
- dbg_sel  in  RSEL_W  register observed on dbg_data
- dbg_data  out  WIDTH  reg[dbg_sel], combinational read
- busy  out  1  high in FETCH and EXEC
- halted  out  1  high in HALTED
- carry  out  1  carry/borrow flag
- zero  out  1  result-zero flag

Behaviour:
- Instruction fields, LSB first: op[2:0], imm[WIDTH+2:3], src (next RSEL_W bits), dst (top RSEL_W bits).
- Opcodes:
  - 000 MUL: low WIDTH bits of reg[src]*imm; carry = (high half != 0)
  - 001 ADD: carry = carry-out
  - 010 SUB: reg[src]-imm; carry = borrow (reg[src] < imm)
  - 011 AND, 100 OR, 101 XOR: carry cleared
  - 110 LDI: reg[dst] = imm; carry unchanged
  - 111 HALT
- zero = (result == 0) for ops 000–110. HALT writes nothing and leaves flags unchanged.
- Reset (CLR=1, async): state IDLE, pc=0, all regs=0, carry=0, zero=0, busy=0, halted=0, rom_oe=0.
- States:
  - IDLE: start=1 -> FETCH, wait counter = ROM_LAT-1.
  - FETCH: rom_oe=1, rom_addr=pc stable. Counter decrements each cycle. On the cycle the counter reaches 0, rom_data is latched into IR and the FSM moves to EXEC. FETCH lasts exactly ROM_LAT cycles.
  - EXEC (1 cycle):
    - HALT -> HALTED; pc not incremented.
    - Otherwise: write reg[dst], update flags, pc = pc+1 modulo 2^PC_W (wraps to 0, no halt).
    - Next state: IDLE if step=1, else FETCH.
  - HALTED: start=1 -> pc=0, flags kept, registers kept, -> FETCH.
- Each instruction takes ROM_LAT+1 cycles (3 at default).
- src==dst is legal: read-before-write, so the result uses the old value.
- start while busy is ignored. step is sampled in EXEC only.
- rom_data is ignored outside the latch cycle.
- dbg_data reflects a write on the cycle after EXEC.
- CLR mid-FETCH or mid-EXEC: immediate return to reset values; any in-flight write is lost.

Test Plan:
- Reset: CLR pulse with arbitrary state -> rom_addr=0, every dbg_sel reads 0x00, busy=0, halted=0, carry=0, zero=0.
- Program {0: LDI r1,0x05; 1: ADD r2=r1+0x03; 2: MUL r3=r2*0x20; 3: HALT}, start 1 cycle -> r1=0x05, r2=0x08, r3=0x00, carry=1, zero=1; halted rises exactly 12 cycles after start; rom_addr=3.
- Program {LDI r0,0xFF; ADD r0=r0+0x01; SUB r1=r0-0x01; HALT}:
  - after ADD: r0=0x00, carry=1, zero=1
  - after SUB: r1=0xFF, carry=1, zero=0
- Step mode, step=1, program of 3 ADDs: each start pulse advances rom_addr by exactly 1; busy is high for 3 cycles per pulse; FSM rests in IDLE between pulses.
- CLR asserted during the 2nd FETCH cycle of instruction 1 -> pc=0, all regs=0 immediately; a new start reruns from address 0 with identical results.
- Wrap, PC_W=2, ROM = 4× ADD r0=r0+0x01, no HALT: after 4 instructions rom_addr=0 and r0=0x04; after 6 instructions r0=0x06, halted stays 0.
